// File: rtl/hex_entry_panel.sv
// hex_entry_panel
// Operator input panel for the board. Four switches select a hex nibble, and
// each Enter press shifts that nibble into an entry buffer. A Commit press
// publishes the buffer on Value together with a one-cycle Valid strobe.
// Both buttons pass through a 2-flop synchroniser, a debouncer and a
// rising-edge detector. The switches pass through a 2-flop synchroniser.
// Every output comes straight from a flop.
module hex_entry_panel #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int NIBBLES         = 4
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [3:0]             SW,
    input  logic                   BtnEnter,
    input  logic                   BtnCommit,
    output logic [4*NIBBLES-1:0]   Value,
    output logic                   Valid,
    output logic [4*NIBBLES-1:0]   Shadow,
    output logic [2:0]             Count,
    output logic                   Entering
);

    // Entry width. The shift needs at least two nibbles, so NIBBLES must be at least 2.
    localparam int VW = 4 * NIBBLES;

    // The debounce counter runs from 0 to DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    COUNT_FULL = 3'(NIBBLES);

    // Button vector index: bit 0 is Enter, bit 1 is Commit.
    localparam int B_ENTER  = 0;
    localparam int B_COMMIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Input conditioning state
    logic [1:0]         btn_meta_q,   btn_meta_d;
    logic [1:0]         btn_sync_q,   btn_sync_d;
    logic [3:0]         sw_meta_q,    sw_meta_d;
    logic [3:0]         sw_sync_q,    sw_sync_d;
    logic [1:0]         db_level_q,   db_level_d;
    logic [1:0]         db_dly_q,     db_dly_d;
    logic [1:0][CW-1:0] db_cnt_q,     db_cnt_d;
    logic [1:0]         press;

    // FSM and output state
    state_t             state_q,      state_d;
    logic [VW-1:0]      value_q,      value_d;
    logic               valid_q,      valid_d;
    logic [VW-1:0]      shadow_q,     shadow_d;
    logic [2:0]         count_q,      count_d;
    logic               entering_q,   entering_d;

    // Shift a new nibble into the low end of the entry buffer.
    function automatic logic [VW-1:0] shift_nibble(input logic [VW-1:0] buf_in,
                                                   input logic [3:0]    nib);
        return {buf_in[VW-5:0], nib};
    endfunction

    // Increment the nibble count, but stop once the buffer is full.
    function automatic logic [2:0] count_sat_inc(input logic [2:0] c);
        return (c >= COUNT_FULL) ? c : c + 3'd1;
    endfunction

    // Two-flop synchronisers for the raw buttons and the switches.
    always_comb begin
        btn_meta_d = {BtnCommit, BtnEnter};
        btn_sync_d = btn_meta_q;
        sw_meta_d  = SW;
        sw_sync_d  = sw_meta_q;
    end

    // Debounce: accept a new level only after it has persisted for DEBOUNCE_CYCLES
    // consecutive cycles. A single cycle that agrees with the current level restarts the count.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_sync_q[i] != db_level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_level_d[i] = btn_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        db_dly_d = db_level_q;
        press    = db_level_q & ~db_dly_q;
    end

    // Entry FSM. In ENTRY, Commit has priority over Enter. COMMIT lasts one cycle
    // and ignores any press that arrives during it.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        shadow_d = shadow_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (press[B_ENTER]) begin
                    shadow_d = {{(VW-4){1'b0}}, sw_sync_q};
                    count_d  = 3'd1;
                    state_d  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (press[B_COMMIT]) begin
                    state_d = ST_COMMIT;
                end else if (press[B_ENTER] && (count_q < COUNT_FULL)) begin
                    shadow_d = shift_nibble(shadow_q, sw_sync_q);
                    count_d  = count_sat_inc(count_q);
                end
            end
            ST_COMMIT: begin
                value_d  = shadow_q;
                valid_d  = 1'b1;
                shadow_d = '0;
                count_d  = 3'd0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        entering_d = (state_d == ST_ENTRY);
    end

    // Registers for the synchronisers and debouncers.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            db_level_q <= '0;
            db_dly_q   <= '0;
            db_cnt_q   <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            db_level_q <= db_level_d;
            db_dly_q   <= db_dly_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Registers for the FSM state and all panel outputs.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            valid_q    <= 1'b0;
            shadow_q   <= '0;
            count_q    <= 3'd0;
            entering_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            entering_q <= entering_d;
        end
    end

    assign Value    = value_q;
    assign Valid    = valid_q;
    assign Shadow   = shadow_q;
    assign Count    = count_q;
    assign Entering = entering_q;

endmodule

// File: tb/tb_hex_entry_panel.sv
// Bench for hex_entry_panel, built with a short debounce window of 4 cycles.
// Each expected committed value is queued when a commit is issued. A monitor
// process pops the queue on every Valid pulse and compares the popped entry with Value.
module tb_hex_entry_panel;

    logic        CLK;
    logic        Reset;
    logic [3:0]  SW;
    logic        BtnEnter;
    logic        BtnCommit;
    logic [15:0] Value;
    logic        Valid;
    logic [15:0] Shadow;
    logic [2:0]  Count;
    logic        Entering;

    int          checks;
    int          errors;
    logic [15:0] exp_q[$];
    bit          mon_en;

    hex_entry_panel #(
        .DEBOUNCE_CYCLES(4),
        .NIBBLES        (4)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .SW       (SW),
        .BtnEnter (BtnEnter),
        .BtnCommit(BtnCommit),
        .Value    (Value),
        .Valid    (Valid),
        .Shadow   (Shadow),
        .Count    (Count),
        .Entering (Entering)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One clean press-and-release on the selected buttons, with SW set beforehand.
    task automatic press(input bit enter, input bit commit, input logic [3:0] nib);
        SW        = nib;
        BtnEnter  = enter;
        BtnCommit = commit;
        idle(10);
        BtnEnter  = 1'b0;
        BtnCommit = 1'b0;
        idle(10);
    endtask

    // Monitor: every Valid pulse must match the oldest queued commit.
    always @(negedge CLK) begin
        if (mon_en && Valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL valid_unexpected actual=%0h required=no_pulse", Value);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (Value !== e) begin
                    errors++;
                    $display("FAIL valid_value actual=%0h required=%0h", Value, e);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        Reset     = 1'b0;
        SW        = 4'h0;
        BtnEnter  = 1'b0;
        BtnCommit = 1'b0;

        // Reset state
        idle(3);
        Reset = 1'b1;
        idle(1);
        chk("rst_value",    Value,    16'h0);
        chk("rst_valid",    Valid,    1'b0);
        chk("rst_shadow",   Shadow,   16'h0);
        chk("rst_count",    Count,    3'd0);
        chk("rst_entering", Entering, 1'b0);
        mon_en = 1'b1;

        // Commit while idle is ignored and produces no Valid pulse.
        press(1'b0, 1'b1, 4'h0);
        chk("idle_commit_count",    Count,    3'd0);
        chk("idle_commit_entering", Entering, 1'b0);

        // Enter 1,2,3,4, then commit.
        press(1'b1, 1'b0, 4'h1);
        chk("first_shadow",   Shadow,   16'h0001);
        chk("first_count",    Count,    3'd1);
        chk("first_entering", Entering, 1'b1);
        press(1'b1, 1'b0, 4'h2);
        press(1'b1, 1'b0, 4'h3);
        press(1'b1, 1'b0, 4'h4);
        chk("t2_shadow", Shadow, 16'h1234);
        chk("t2_count",  Count,  3'd4);
        exp_q.push_back(16'h1234);
        press(1'b0, 1'b1, 4'h4);
        chk("t2_post_shadow",   Shadow,   16'h0);
        chk("t2_post_count",    Count,    3'd0);
        chk("t2_post_entering", Entering, 1'b0);
        chk("t2_value_hold",    Value,    16'h1234);

        // Five Enter presses. The fifth is ignored because the buffer is full.
        press(1'b1, 1'b0, 4'hA);
        press(1'b1, 1'b0, 4'hB);
        press(1'b1, 1'b0, 4'hC);
        press(1'b1, 1'b0, 4'hD);
        chk("t3_four_shadow", Shadow, 16'hABCD);
        press(1'b1, 1'b0, 4'hE);
        chk("t3_sat_shadow", Shadow, 16'hABCD);
        chk("t3_sat_count",  Count,  3'd4);
        exp_q.push_back(16'hABCD);
        press(1'b0, 1'b1, 4'hE);
        chk("t3_value", Value, 16'hABCD);

        // A bouncing Enter produces no event. A steady hold then gives exactly one.
        SW = 4'h1;
        for (int i = 0; i < 5; i++) begin
            BtnEnter = 1'b1;
            idle(2);
            BtnEnter = 1'b0;
            idle(2);
        end
        chk("t4_bounce_count",    Count,    3'd0);
        chk("t4_bounce_entering", Entering, 1'b0);
        BtnEnter = 1'b1;
        idle(10);
        BtnEnter = 1'b0;
        idle(10);
        chk("t4_count",  Count,  3'd1);
        chk("t4_shadow", Shadow, 16'h0001);
        press(1'b1, 1'b0, 4'h2);
        chk("t5_pre_shadow", Shadow, 16'h0012);

        // Enter and Commit in the same cycle: Commit wins and the nibble is discarded.
        exp_q.push_back(16'h0012);
        press(1'b1, 1'b1, 4'h7);
        chk("t5_value",  Value,  16'h0012);
        chk("t5_shadow", Shadow, 16'h0);
        chk("t5_count",  Count,  3'd0);

        // Reset in the middle of an entry clears everything and produces no commit.
        press(1'b1, 1'b0, 4'h5);
        press(1'b1, 1'b0, 4'h6);
        chk("t6_pre_shadow", Shadow, 16'h0056);
        chk("t6_pre_count",  Count,  3'd2);
        Reset = 1'b0;
        idle(3);
        chk("t6_shadow",   Shadow,   16'h0);
        chk("t6_count",    Count,    3'd0);
        chk("t6_entering", Entering, 1'b0);
        chk("t6_value",    Value,    16'h0);
        chk("t6_valid",    Valid,    1'b0);
        Reset = 1'b1;
        idle(5);
        chk("t6_post_value",    Value,    16'h0);
        chk("t6_post_entering", Entering, 1'b0);

        // Every queued commit must have been seen on Valid.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_commits actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
